bad_pixel_replace: RTL and testbench
====================================

# bad_pixel_replace

Bad-pixel detection and replacement stage that sits directly downstream of `pixel_sort_asc`. It consumes the eight ascending-sorted neighbour pixels together with the matching centre pixel. A centre pixel outside a threshold-widened band of its neighbours is flagged hot or cold and replaced by the neighbour median. The block also keeps per-frame defect counters.

## Interface
- `PIX_W`, 16: pixel width in bits.
- `CNT_W`, 16: width of the defect counters.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low.
- `enable` input 1: input-valid qualifier; the sorted set and the centre pixel are sampled when high. Driven by `pixel_sort_asc` `valid_out`.
- `Sorted_in1`..`Sorted_in8` input PIX_W each: neighbours in ascending order (`Sorted_in1` is the minimum).
- `Pixel_center` input PIX_W: centre pixel, time-aligned with the sorted set by upstream.
- `thresh` input PIX_W: detection margin; quasi-static, sampled with `enable`.
- `bypass` input 1: when high, the centre pixel passes unmodified and no defects are counted.
- `frame_start` input 1: one-cycle pulse marking a frame boundary.
- `valid_out` output 1: `Pixel_out` and the flags are valid.
- `Pixel_out` output PIX_W: corrected pixel.
- `hot_flag` / `cold_flag` output 1 each: defect class for the current output.
- `defect_count` output CNT_W: running defect count for the current frame.
- `last_frame_count` output CNT_W: count latched at the last `frame_start`.

## Operation
- Stage 1 registers values when `enable`=1:
  - `lo` = `Sorted_in2` and `hi` = `Sorted_in7` (the extreme neighbour on each side is discarded).
  - `lo_lim` = `lo - thresh`, saturating at 0.
  - `hi_lim` = `hi + thresh`, saturating at 2^PIX_W-1.
  - `median` = (`Sorted_in4` + `Sorted_in5` + 1) >> 1, computed with a PIX_W+1-bit sum so the result never overflows.
  - The centre pixel, `bypass` and a stage valid bit are also registered.
- Stage 2 decides and registers the output:
  - cold = centre < `lo_lim`; hot = centre > `hi_lim`. The comparisons are strict, so equality is not a defect.
  - When (hot or cold) and not `bypass`: `Pixel_out` = `median`, with the matching flag set.
  - Otherwise `Pixel_out` = centre and both flags are 0.
- Valid bits propagate unconditionally. There is no backpressure: the downstream stage must accept one pixel per cycle.
- Counter behaviour:
  - `defect_count` increments on each stage-2 output with a flag set, saturating at 2^CNT_W-1.
  - On `frame_start`, `last_frame_count` takes the pre-clear value of `defect_count`, and `defect_count` is cleared.
  - If `frame_start` and a defect output occur in the same cycle, the defect belongs to the new frame: `last_frame_count` gets the old value and `defect_count` becomes 1.
- The block has no FSM; it is a two-stage pipeline plus a counter.

## Timing
- Latency is 2 cycles: inputs sampled at edge N appear on the outputs after edge N+1, and `valid_out` is high from edge N+1 to edge N+2.
- Throughput is one pixel per cycle. Back-to-back `enable` gives back-to-back `valid_out`.
- When `enable`=0, the stage valid bit clears. Data registers may hold stale values, but `valid_out`=0.
- Reset values: every output and internal register is 0 (`valid_out`, `Pixel_out`, both flags, both counters).
- Reset asserted mid-stream flushes the pipeline immediately. No output is produced for pixels that were in flight.
- Between `frame_start` and the next update, the counters are visible one cycle after the edge.
- `bypass` takes effect per pixel, aligned with `enable`. Toggling it mid-stream affects only the pixels sampled while it is high.

## Structure
- Shared package `bpr_pkg` holds the `PIX_W` and `CNT_W` defaults plus a `sat_add` / `sat_sub` helper function; it is reused by `pixel_sort_asc` and the later line-buffer stage.
- One sub-module, `bpr_defect_counter`: saturating counter with frame latch, handling the increment, clear and latch priority described above.
- All remaining logic is flat in `bad_pixel_replace`.

## Test plan
Scenarios 1–3 use neighbours 45, 55, 234, 344, 345, 345, 456, 1037, giving `lo` = 55, `hi` = 456 and `median` = 345.
- Scenario 1, hot pixel: `thresh` = 100, centre 600. Expect `hot_flag` = 1, `Pixel_out` = 345, `valid_out` 2 cycles after `enable`, and `defect_count` = 1.
- Scenario 2, cold pixel and saturation at 0: with `thresh` = 10, `lo_lim` = 45; centre 20 gives `cold_flag` = 1 and `Pixel_out` = 345. With `thresh` = 100, `lo_lim` saturates to 0; centre 0 gives no flag and `Pixel_out` = 0.
- Scenario 3, equality and bypass: `thresh` = 100, centre 556 (equal to `hi_lim`) gives no flag and `Pixel_out` = 556. Centre 600 with `bypass` = 1 gives `Pixel_out` = 600, no flag and no count.
- Scenario 4, high saturation: neighbours all 65500, `thresh` = 100, centre 65535. Expect `hi_lim` = 65535, no flag and `Pixel_out` = 65535.
- Scenario 5, frame accounting: drive 5 consecutive defects, then `frame_start` in the same cycle as a 6th defect output. Expect `last_frame_count` = 5 and `defect_count` = 1. Drive 2^CNT_W+3 defects and expect saturation at 65535.
- Scenario 6, reset mid-stream: drive continuous `enable` and assert `reset` low for one cycle. Expect all outputs 0 asynchronously, and `valid_out` to remain low until 2 cycles after the first post-reset `enable`.

Source files
------------

// File: rtl/bpr_pkg.sv
// bpr_pkg: shared pixel/counter widths and saturating arithmetic helpers.
// Ports: none (package). Provides PIX_W, CNT_W, pix_t, sat_add, sat_sub.
package bpr_pkg;
   localparam int PIX_W = 16;
   localparam int CNT_W = 16;
   typedef logic [PIX_W-1:0] pix_t;
   function automatic pix_t sat_add(pix_t a, pix_t b);
      logic [PIX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[PIX_W] ? '1 : s[PIX_W-1:0];
   endfunction
   function automatic pix_t sat_sub(pix_t a, pix_t b);
      return (a < b) ? '0 : a - b;
   endfunction
endpackage

// File: rtl/bad_pixel_replace_if.sv
// bad_pixel_replace_if: pixel stream bundle between sorter/testbench and bad_pixel_replace.
// Inputs to the block: enable, Sorted_in1..8, Pixel_center, thresh, bypass, frame_start.
// Outputs from the block: valid_out, Pixel_out, hot_flag, cold_flag, defect_count, last_frame_count.
interface bad_pixel_replace_if;
   import bpr_pkg::*;
   logic             enable;
   pix_t             Sorted_in1, Sorted_in2, Sorted_in3, Sorted_in4;
   pix_t             Sorted_in5, Sorted_in6, Sorted_in7, Sorted_in8;
   pix_t             Pixel_center;
   pix_t             thresh;
   logic             bypass;
   logic             frame_start;
   logic             valid_out;
   pix_t             Pixel_out;
   logic             hot_flag;
   logic             cold_flag;
   logic [CNT_W-1:0] defect_count;
   logic [CNT_W-1:0] last_frame_count;
   modport master (
      output enable, Sorted_in1, Sorted_in2, Sorted_in3, Sorted_in4,
             Sorted_in5, Sorted_in6, Sorted_in7, Sorted_in8,
             Pixel_center, thresh, bypass, frame_start,
      input  valid_out, Pixel_out, hot_flag, cold_flag, defect_count, last_frame_count
   );
   modport slave (
      input  enable, Sorted_in1, Sorted_in2, Sorted_in3, Sorted_in4,
             Sorted_in5, Sorted_in6, Sorted_in7, Sorted_in8,
             Pixel_center, thresh, bypass, frame_start,
      output valid_out, Pixel_out, hot_flag, cold_flag, defect_count, last_frame_count
   );
endinterface

// File: rtl/bpr_defect_counter.sv
// bpr_defect_counter: saturating per-frame defect counter with frame-boundary latch.
// Ports: clk, reset (async active-low), frame_start_i (clear+latch pulse), inc_i (defect event),
//        count_o (current frame count), last_o (count latched at last frame_start).
module bpr_defect_counter #(
   parameter int CNT_W = bpr_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] last_o
);
   logic [CNT_W-1:0] count_q, count_d, last_q, last_d;
   // A defect coinciding with frame_start belongs to the new frame, so it restarts the count at 1.
   always_comb begin
      count_d = frame_start_i ? CNT_W'(inc_i)
              : (inc_i && count_q != '1) ? count_q + CNT_W'(1) : count_q;
      last_d  = frame_start_i ? count_q : last_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         last_q  <= '0;
      end else begin
         count_q <= count_d;
         last_q  <= last_d;
      end
   end
   assign count_o = count_q;
   assign last_o  = last_q;
endmodule

// File: rtl/bad_pixel_replace.sv
// bad_pixel_replace: two-stage hot/cold pixel detector that replaces outliers by the neighbour median.
// Ports: clk, reset (async active-low), bus (slave side of bad_pixel_replace_if carrying the
//        sorted neighbours, centre pixel, controls, corrected pixel, flags and defect counters).
module bad_pixel_replace
   import bpr_pkg::*;
(
   input logic              clk,
   input logic              reset,
   bad_pixel_replace_if.slave bus
);
   logic           s1_v_q, s1_v_d, byp_q, byp_d;
   pix_t           lo_lim_q, lo_lim_d, hi_lim_q, hi_lim_d, med_q, med_d, ctr_q, ctr_d;
   logic           v_q, v_d, hot_q, hot_d, cold_q, cold_d;
   pix_t           pix_q, pix_d;
   logic [PIX_W:0] med_sum;
   logic           hot, cold, fix;
   logic [CNT_W-1:0] cnt, last;
   logic           unused_nbr;
   // The outermost neighbours only serve to make the band robust; they are deliberately ignored.
   assign unused_nbr = ^{bus.Sorted_in1, bus.Sorted_in3, bus.Sorted_in6, bus.Sorted_in8};
   // Extra bit on the sum keeps the rounded median exact at full scale.
   assign med_sum = {1'b0, bus.Sorted_in4} + {1'b0, bus.Sorted_in5} + (PIX_W+1)'(1);
   always_comb begin
      s1_v_d   = bus.enable;
      lo_lim_d = bus.enable ? sat_sub(bus.Sorted_in2, bus.thresh) : lo_lim_q;
      hi_lim_d = bus.enable ? sat_add(bus.Sorted_in7, bus.thresh) : hi_lim_q;
      med_d    = bus.enable ? med_sum[PIX_W:1] : med_q;
      ctr_d    = bus.enable ? bus.Pixel_center : ctr_q;
      byp_d    = bus.enable ? bus.bypass : byp_q;
   end
   always_comb begin
      cold   = ctr_q < lo_lim_q;
      hot    = ctr_q > hi_lim_q;
      fix    = !byp_q && (hot || cold);
      v_d    = s1_v_q;
      pix_d  = s1_v_q ? (fix ? med_q : ctr_q) : pix_q;
      hot_d  = s1_v_q ? (!byp_q && hot) : hot_q;
      cold_d = s1_v_q ? (!byp_q && cold) : cold_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v_q   <= 1'b0;
         byp_q    <= 1'b0;
         lo_lim_q <= '0;
         hi_lim_q <= '0;
         med_q    <= '0;
         ctr_q    <= '0;
         v_q      <= 1'b0;
         pix_q    <= '0;
         hot_q    <= 1'b0;
         cold_q   <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         byp_q    <= byp_d;
         lo_lim_q <= lo_lim_d;
         hi_lim_q <= hi_lim_d;
         med_q    <= med_d;
         ctr_q    <= ctr_d;
         v_q      <= v_d;
         pix_q    <= pix_d;
         hot_q    <= hot_d;
         cold_q   <= cold_d;
      end
   end
   // Count on the same edge the flagged pixel is registered, so the count tracks the visible output.
   bpr_defect_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk           (clk),
      .reset         (reset),
      .frame_start_i (bus.frame_start),
      .inc_i         (s1_v_q && fix),
      .count_o       (cnt),
      .last_o        (last)
   );
   assign bus.valid_out        = v_q;
   assign bus.Pixel_out        = pix_q;
   assign bus.hot_flag         = hot_q;
   assign bus.cold_flag        = cold_q;
   assign bus.defect_count     = cnt;
   assign bus.last_frame_count = last;
endmodule

// File: tb/tb_bad_pixel_replace.sv
// tb_bad_pixel_replace: scoreboard bench for bad_pixel_replace with a behavioural reference model.
module tb_bad_pixel_replace;
   typedef struct {
      int due;
      int pix;
      bit hot;
      bit cold;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   bad_pixel_replace_if bus ();
   bad_pixel_replace dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   exp_t sb[$];
   int   nb[8];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cnt_m = 0;
   int   last_m = 0;
   logic fs_seen = 1'b0;
   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      fs_seen <= reset & bus.frame_start;
   end
   // Monitor: decides whether an output is due, pops and compares, and models the frame counters.
   always @(negedge clk) begin
      if (reset) begin
         automatic bit   ev  = sb.size() > 0 && sb[0].due == cyc;
         automatic bit   dfx = 1'b0;
         automatic exp_t e;
         chk("valid_out", int'(bus.valid_out), int'(ev));
         if (ev) begin
            e = sb.pop_front();
            chk("Pixel_out", int'(bus.Pixel_out), e.pix);
            chk("hot_flag", int'(bus.hot_flag), int'(e.hot));
            chk("cold_flag", int'(bus.cold_flag), int'(e.cold));
            dfx = e.hot | e.cold;
         end
         if (fs_seen) begin
            last_m = cnt_m;
            cnt_m  = int'(dfx);
         end else if (dfx && cnt_m < 65535) cnt_m++;
         chk("defect_count", int'(bus.defect_count), cnt_m);
         chk("last_frame_count", int'(bus.last_frame_count), last_m);
      end
   end
   // Drive one cycle of stimulus at a negedge and queue the expected response from the spec rules.
   task automatic send(int c, int th, bit byp, bit fs, bit en);
      int lo_lim, hi_lim, med;
      exp_t e;
      bus.enable       = en;
      bus.Sorted_in1   = 16'(nb[0]);
      bus.Sorted_in2   = 16'(nb[1]);
      bus.Sorted_in3   = 16'(nb[2]);
      bus.Sorted_in4   = 16'(nb[3]);
      bus.Sorted_in5   = 16'(nb[4]);
      bus.Sorted_in6   = 16'(nb[5]);
      bus.Sorted_in7   = 16'(nb[6]);
      bus.Sorted_in8   = 16'(nb[7]);
      bus.Pixel_center = 16'(c);
      bus.thresh       = 16'(th);
      bus.bypass       = byp;
      bus.frame_start  = fs;
      if (en) begin
         lo_lim = nb[1] - th < 0 ? 0 : nb[1] - th;
         hi_lim = nb[6] + th > 65535 ? 65535 : nb[6] + th;
         med    = (nb[3] + nb[4] + 1) / 2;
         e.due  = cyc + 2;
         e.cold = !byp && c < lo_lim;
         e.hot  = !byp && c > hi_lim;
         e.pix  = (e.hot || e.cold) ? med : c;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask
   task automatic set_nb(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
      nb[0] = a0; nb[1] = a1; nb[2] = a2; nb[3] = a3;
      nb[4] = a4; nb[5] = a5; nb[6] = a6; nb[7] = a7;
   endtask
   task automatic check_zero(string tag);
      chk({tag, "_valid_out"}, int'(bus.valid_out), 0);
      chk({tag, "_Pixel_out"}, int'(bus.Pixel_out), 0);
      chk({tag, "_hot_flag"}, int'(bus.hot_flag), 0);
      chk({tag, "_cold_flag"}, int'(bus.cold_flag), 0);
      chk({tag, "_defect_count"}, int'(bus.defect_count), 0);
      chk({tag, "_last_frame_count"}, int'(bus.last_frame_count), 0);
   endtask
   initial begin
      set_nb(0, 0, 0, 0, 0, 0, 0, 0);
      bus.enable = 0; bus.bypass = 0; bus.frame_start = 0;
      bus.thresh = 0; bus.Pixel_center = 0;
      bus.Sorted_in1 = 0; bus.Sorted_in2 = 0; bus.Sorted_in3 = 0; bus.Sorted_in4 = 0;
      bus.Sorted_in5 = 0; bus.Sorted_in6 = 0; bus.Sorted_in7 = 0; bus.Sorted_in8 = 0;
      #1 reset = 1'b0;
      #1 check_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      // Scenarios 1-3: lo = 55, hi = 456, median = 345.
      set_nb(45, 55, 234, 344, 345, 345, 456, 1037);
      send(600, 100, 0, 0, 1);
      send(20, 10, 0, 0, 1);
      send(0, 100, 0, 0, 1);
      send(556, 100, 0, 0, 1);
      send(600, 100, 1, 0, 1);
      send(45, 10, 0, 0, 1);
      send(44, 10, 0, 0, 1);
      // Scenario 4: high-side saturation.
      set_nb(65500, 65500, 65500, 65500, 65500, 65500, 65500, 65500);
      send(65535, 100, 0, 0, 1);
      set_nb(65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535);
      send(0, 0, 0, 0, 1);
      repeat (3) send(0, 0, 0, 0, 0);
      // Scenario 5: frame accounting with a defect landing on the frame_start edge.
      set_nb(45, 55, 234, 344, 345, 345, 456, 1037);
      send(0, 0, 0, 1, 0);
      repeat (2) send(0, 0, 0, 0, 0);
      repeat (6) send(600, 100, 0, 0, 1);
      send(300, 100, 0, 1, 1);
      repeat (3) send(0, 0, 0, 0, 0);
      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         int q[$];
         int base, spr, th, r, c;
         base = $urandom_range(0, 65535);
         spr  = $urandom_range(0, 3000);
         for (int k = 0; k < 8; k++) begin
            int v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : base + $urandom_range(0, spr);
            q.push_back(v > 65535 ? 65535 : v);
         end
         q.sort();
         for (int k = 0; k < 8; k++) nb[k] = q[k];
         th = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 2000);
         r  = $urandom_range(0, 2);
         c  = (r == 0) ? $urandom_range(0, 65535)
            : (r == 1) ? nb[1] - th + $urandom_range(0, 4) - 2
            : nb[6] + th + $urandom_range(0, 4) - 2;
         c = c < 0 ? 0 : c > 65535 ? 65535 : c;
         send(c, th, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
      end
      // Counter saturation: 2^CNT_W+3 back-to-back defects, then latch the saturated count.
      send(0, 0, 0, 1, 0);
      set_nb(100, 100, 100, 100, 100, 100, 100, 100);
      repeat (65539) send(65535, 0, 0, 0, 1);
      repeat (2) send(0, 0, 0, 0, 0);
      send(0, 0, 0, 1, 0);
      repeat (2) send(0, 0, 0, 0, 0);
      // Scenario 6: reset during continuous enable flushes everything in flight.
      set_nb(45, 55, 234, 344, 345, 345, 456, 1037);
      repeat (4) send(600, 100, 0, 0, 1);
      #2 reset = 1'b0;
      #1 check_zero("midreset");
      sb.delete();
      cnt_m  = 0;
      last_m = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) send(600, 100, 0, 0, 1);
      send(300, 100, 0, 0, 1);
      repeat (4) send(0, 0, 0, 0, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
